// File: rtl/mdac_pkg.sv
// -----------------------------------------------------------------------------
// mdac_pkg
//   Shared definitions for the mdac datapath blocks.
//   - state_t      : control state encoding for the shift-and-add multiplier.
//                    2'b11 is not a legal state; the FSM recovers to S_IDLE
//                    from it on the next clock edge.
//   - DEFAULT_WIDTH: default operand width used by the multiplier.
// -----------------------------------------------------------------------------
package mdac_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage : mdac_pkg

// File: rtl/mul_iter_counter.sv
// -----------------------------------------------------------------------------
// mul_iter_counter
//   Iteration counter for the shift-and-add multiplier. Counts the RUN steps
//   and flags the step on which the final multiplier bit is consumed.
//
//   Parameters:
//     WIDTH  - number of iterations per operation (operand width)
//     CW     - counter width; must be able to hold WIDTH
//   Ports:
//     clk    - system clock, rising edge
//     reset  - synchronous active-high reset, clears the count
//     clear  - synchronous clear (new operation accepted)
//     enable - advance the count by one
//     last   - high while count == WIDTH-1 (final iteration)
// -----------------------------------------------------------------------------
module mul_iter_counter #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic last
);

  logic [CW-1:0] count;

  // NOTE: clocked state is always written with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == CW'(WIDTH - 1));

endmodule : mul_iter_counter

// File: rtl/shift_add_mul.sv
// -----------------------------------------------------------------------------
// shift_add_mul
//   Sequential unsigned shift-and-add multiplier. An operation is accepted on
//   start while idle, then one multiplier bit is consumed per clock for WIDTH
//   clocks. The full 2*WIDTH-bit product is published on the edge that enters
//   DONE, where a single-cycle done strobe is raised.
//
//   Parameters:
//     WIDTH   - operand width, 2..16
//     CW      - iteration counter width (derived, do not override)
//   Ports:
//     clk     - system clock, rising edge
//     reset   - synchronous active-high reset, highest priority
//     start   - request pulse, only sampled in IDLE
//     a       - multiplicand, captured on accepted start
//     b       - multiplier, captured on accepted start
//     busy    - high in RUN and DONE
//     done    - one-cycle strobe, product valid and freshly updated
//     product - last completed result, held until the next completion
// -----------------------------------------------------------------------------
module shift_add_mul
  import mdac_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  state_t               state;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic                 accept;
  logic                 last;

  // A new operation is only taken while idle; start in RUN/DONE is ignored.
  assign accept = (state == S_IDLE) && start;

  // Accumulator value after the current step, including this step's add.
  // Used both for the running sum and for the final product, so the product
  // captured on the last step already contains the last partial product.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  mul_iter_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_iter_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (state == S_RUN),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            state  <= S_RUN;
          end
        end

        S_RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (last) begin
            product <= acc_next;
            state   <= S_DONE;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        // Illegal encoding 2'b11: fall back to IDLE without touching product.
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Moore outputs decoded directly from the state register.
  assign busy = (state == S_RUN) || (state == S_DONE);
  assign done = (state == S_DONE);

endmodule : shift_add_mul

// File: tb/tb_shift_add_mul.sv
// -----------------------------------------------------------------------------
// tb_shift_add_mul
//   Self-checking bench for shift_add_mul (WIDTH=4). A cycle-level reference
//   model (operation countdown + integer multiply) is compared against the DUT
//   every cycle; directed sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_shift_add_mul;

  localparam int WIDTH = 4;
  localparam int LAT   = WIDTH + 1;   // cycles from acceptance to done

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  int checks = 0;
  int errors = 0;

  shift_add_mul #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: an accepted operation keeps the block busy for WIDTH+1
  // cycles; the last of those is the done cycle, on whose entry the product
  // becomes a*b. Inputs are sampled on the rising edge like the DUT.
  // ---------------------------------------------------------------------------
  int m_left = 0;
  int m_pend = 0;
  int m_prod = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0;
      m_prod = 0;
    end else if (m_left == 0) begin
      if (start) begin
        m_left = LAT;
        m_pend = int'(a) * int'(b);
      end
    end else begin
      if (m_left == 2) m_prod = m_pend;
      m_left = m_left - 1;
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("model_busy",    32'(busy),    32'(m_left > 0));
    check("model_done",    32'(done),    32'(m_left == 1));
    check("model_product", 32'(product), 32'(m_prod));
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done; lat counts negedges, 1 = first cycle after
  // acceptance. busy_cycles counts sampled busy cycles up to and incl. done.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = -1;
    busy_cycles = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                        input int exp_prod, input string tag);
    int lat, bc;
    a = op_a;
    b = op_b;
    start = 1'b1;
    cycle();
    start = 1'b0;
    wait_done(lat, bc);
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_busy_cycles"}, 32'(bc), 32'(LAT));
    check({tag, "_product"}, 32'(product), 32'(exp_prod));
    cycle();
  endtask

  initial begin
    int lat, bc, extra_done;

    // 1. Reset held two cycles with start asserted.
    reset = 1'b1;
    start = 1'b1;
    a = 4'd3;
    b = 4'd5;
    repeat (2) cycle();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    start = 1'b0;
    reset = 1'b0;
    cycle();
    check("after_reset_idle", 32'(busy), 32'd0);

    // 2. Basic multiply.
    run_op(4'd3, 4'd5, 15, "basic_3x5");

    // 3. Extremes and zero operands.
    run_op(4'd15, 4'd15, 225, "max_15x15");
    check("max_literal", 32'(product), 32'hE1);
    run_op(4'd0, 4'd9, 0, "zero_a");
    run_op(4'd9, 4'd0, 0, "zero_b");

    // 4. start while busy is ignored.
    a = 4'd3;
    b = 4'd5;
    start = 1'b1;
    cycle();
    a = 4'd7;
    b = 4'd7;
    wait_done(lat, bc);
    start = 1'b0;
    check("busy_start_latency", 32'(lat), 32'(LAT));
    check("busy_start_product", 32'(product), 32'd15);
    extra_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    check("busy_start_single_done", 32'(extra_done), 32'd0);
    check("busy_start_product_held", 32'(product), 32'd15);

    // 5. Reset on the second RUN cycle.
    cycle();
    a = 4'd6;
    b = 4'd7;
    start = 1'b1;
    cycle();          // now in RUN cycle 1
    start = 1'b0;
    cycle();          // now in RUN cycle 2
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    @(negedge clk);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_product", 32'(product), 32'd0);
    extra_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    check("midreset_no_done", 32'(extra_done), 32'd0);
    cycle();
    run_op(4'd6, 4'd7, 42, "after_reset_6x7");

    // 6. Back-to-back with start held high.
    a = 4'd2;
    b = 4'd3;
    start = 1'b1;
    cycle();
    wait_done(lat, bc);
    check("b2b_first_latency", 32'(lat), 32'(LAT));
    check("b2b_first_product", 32'(product), 32'd6);
    a = 4'd4;
    b = 4'd4;
    @(negedge clk);   // IDLE cycle where the second op is accepted
    check("b2b_idle_gap", 32'(busy), 32'd0);
    wait_done(lat, bc);
    start = 1'b0;
    check("b2b_second_latency", 32'(lat), 32'(LAT));
    check("b2b_second_product", 32'(product), 32'd16);
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule : tb_shift_add_mul
